// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NREQ writeback sources.
// Define RF_ARB_FIXED_PRIO_EN for fixed priority (lowest valid index wins, no rr pointer).
module regfile_wb_arbiter #(
  parameter  int NREQ  = 3,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*5-1:0] req_adr,
  input  logic [NREQ*32-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              stall,
  output logic              rf_en,
  output logic [4:0]        rf_w_adr,
  output logic [31:0]       rf_w_data,
  input  logic [4:0]        adr1,
  input  logic [4:0]        adr2,
  output logic              hit1,
  output logic              hit2
);

  logic [4:0]       adr_a  [NREQ];
  logic [31:0]      data_a [NREQ];
  logic [IDX_W-1:0] rr_ptr, gidx, scan;
  logic [IDX_W:0]   sum;
  logic             xfer;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign adr_a[i]  = req_adr[5*i +: 5];
    assign data_a[i] = req_data[32*i +: 32];
  end

  // Scan from rr_ptr upward with explicit wrap; a grant always implies valid,
  // so xfer doubles as the transfer strobe for the output stage.
  always_comb begin
    req_ready = '0;
    xfer      = 1'b0;
    gidx      = '0;
    sum       = '0;
    scan      = '0;
    if (rst_n && !stall) begin
      for (int k = 0; k < NREQ; k++) begin
        sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
        if (sum >= (IDX_W+1)'(NREQ)) sum = sum - (IDX_W+1)'(NREQ);
        scan = sum[IDX_W-1:0];
        if (!xfer && req_valid[scan]) begin
          req_ready[scan] = 1'b1;
          xfer            = 1'b1;
          gidx            = scan;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_en     <= 1'b0;
      rf_w_adr  <= '0;
      rf_w_data <= '0;
    end else begin
      rf_en <= 1'b0;
      // x0 writes are consumed but never reach the port
      if (xfer && adr_a[gidx] != 5'd0) begin
        rf_en     <= 1'b1;
        rf_w_adr  <= adr_a[gidx];
        rf_w_data <= data_a[gidx];
      end
    end
  end

`ifdef RF_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_ptr <= '0;
    else if (xfer)
      rr_ptr <= (gidx == IDX_W'(NREQ-1)) ? '0 : gidx + 1'b1;
  end
`endif

  assign hit1 = rf_en && (rf_w_adr == adr1);
  assign hit2 = rf_en && (rf_w_adr == adr2);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (NREQ=3).
module tb_regfile_wb_arbiter;
  localparam int NREQ = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*5-1:0] req_adr;
  logic [NREQ*32-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              stall;
  logic              rf_en;
  logic [4:0]        rf_w_adr;
  logic [31:0]       rf_w_data;
  logic [4:0]        adr1, adr2;
  logic              hit1, hit2;

  int errors = 0;
  int checks = 0;

  regfile_wb_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_adr(req_adr),
    .req_data(req_data), .req_ready(req_ready), .stall(stall), .rf_en(rf_en),
    .rf_w_adr(rf_w_adr), .rf_w_data(rf_w_data), .adr1(adr1), .adr2(adr2),
    .hit1(hit1), .hit2(hit2)
  );

  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    req_adr[5*i +: 5]   = a;
    req_data[32*i +: 32] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; req_valid = 3'b111;
    req_adr = '0; req_data = '0; adr1 = '0; adr2 = '0;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
    checks++;
    if (rf_en !== 1'b0 || rf_w_adr !== 5'd0 || rf_w_data !== 32'd0) begin
      errors++; $display("FAIL reset_out got en=%b adr=%0d data=%h exp 0/0/0", rf_en, rf_w_adr, rf_w_data);
    end
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    set_req(1, 5'd5, 32'hDEADBEEF);
    req_valid = 3'b010; #1;
    checks++;
    if (req_ready !== 3'b010) begin errors++; $display("FAIL single_ready got=%b exp=010", req_ready); end
    @(posedge clk); #1;
    checks++;
    if (rf_en !== 1'b1 || rf_w_adr !== 5'd5 || rf_w_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_write got en=%b adr=%0d data=%h exp 1/5/deadbeef", rf_en, rf_w_adr, rf_w_data);
    end
    @(negedge clk);
    req_valid = '0;
    @(posedge clk); #1;
    checks++;
    if (rf_en !== 1'b0 || rf_w_adr !== 5'd5) begin
      errors++; $display("FAIL single_drop got en=%b adr=%0d exp 0/5", rf_en, rf_w_adr);
    end
    // pointer should now be 2
    @(negedge clk);
    req_valid = 3'b111; #1;
    checks++;
    if (req_ready !== 3'b100) begin errors++; $display("FAIL single_ptr got=%b exp=100", req_ready); end
    #1 req_valid = '0;
  endtask

  task automatic test_x0();
    @(negedge clk);
    set_req(0, 5'd0, 32'h1234);
    req_valid = 3'b001; #1;
    checks++;
    if (req_ready !== 3'b001) begin errors++; $display("FAIL x0_ready got=%b exp=001", req_ready); end
    @(posedge clk); #1;
    checks++;
    if (rf_en !== 1'b0 || rf_w_adr !== 5'd5 || rf_w_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL x0_hold got en=%b adr=%0d data=%h exp 0/5/deadbeef", rf_en, rf_w_adr, rf_w_data);
    end
    @(negedge clk);
    req_valid = 3'b111; #1;
    checks++;
    if (req_ready !== 3'b010) begin errors++; $display("FAIL x0_ptr got=%b exp=010", req_ready); end
    #1 req_valid = '0;
  endtask

  task automatic test_stall();
    // req1 transfer moves the pointer to 2
    @(negedge clk);
    set_req(1, 5'd9, 32'h11);
    req_valid = 3'b010;
    @(posedge clk); #1;
    checks++;
    if (rf_en !== 1'b1 || rf_w_adr !== 5'd9) begin
      errors++; $display("FAIL stall_pre got en=%b adr=%0d exp 1/9", rf_en, rf_w_adr);
    end
    set_req(0, 5'd4, 32'h44);
    set_req(2, 5'd3, 32'h33);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      stall = 1'b1; req_valid = 3'b101; #1;
      checks++;
      if (req_ready !== 3'b000) begin errors++; $display("FAIL stall_ready[%0d] got=%b exp=000", c, req_ready); end
      @(posedge clk); #1;
      checks++;
      if (rf_en !== 1'b0 || rf_w_adr !== 5'd9) begin
        errors++; $display("FAIL stall_en[%0d] got en=%b adr=%0d exp 0/9", c, rf_en, rf_w_adr);
      end
    end
    @(negedge clk);
    stall = 1'b0; #1;
    checks++;
    if (req_ready !== 3'b100) begin errors++; $display("FAIL stall_first got=%b exp=100", req_ready); end
    @(posedge clk); #1;
    checks++;
    if (rf_en !== 1'b1 || rf_w_adr !== 5'd3 || rf_w_data !== 32'h33) begin
      errors++; $display("FAIL stall_w2 got en=%b adr=%0d data=%h exp 1/3/33", rf_en, rf_w_adr, rf_w_data);
    end
    @(negedge clk);
    req_valid = 3'b001; #1;
    checks++;
    if (req_ready !== 3'b001) begin errors++; $display("FAIL stall_second got=%b exp=001", req_ready); end
    @(posedge clk); #1;
    checks++;
    if (rf_en !== 1'b1 || rf_w_adr !== 5'd4 || rf_w_data !== 32'h44) begin
      errors++; $display("FAIL stall_w0 got en=%b adr=%0d data=%h exp 1/4/44", rf_en, rf_w_adr, rf_w_data);
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_hazard();
    @(negedge clk);
    set_req(0, 5'd7, 32'h77);
    req_valid = 3'b001;
    @(posedge clk); #1;
    req_valid = '0; adr1 = 5'd7; adr2 = 5'd7; #1;
    checks++;
    if (rf_en !== 1'b1 || hit1 !== 1'b1 || hit2 !== 1'b1) begin
      errors++; $display("FAIL hazard_both got en=%b h1=%b h2=%b exp 1/1/1", rf_en, hit1, hit2);
    end
    adr1 = 5'd8; #1;
    checks++;
    if (hit1 !== 1'b0 || hit2 !== 1'b1) begin
      errors++; $display("FAIL hazard_miss got h1=%b h2=%b exp 0/1", hit1, hit2);
    end
    @(posedge clk); #1;
    adr1 = 5'd7; #1;
    checks++;
    if (rf_en !== 1'b0 || rf_w_adr !== 5'd7 || hit1 !== 1'b0 || hit2 !== 1'b0) begin
      errors++; $display("FAIL hazard_gated got en=%b adr=%0d h1=%b h2=%b exp 0/7/0/0", rf_en, rf_w_adr, hit1, hit2);
    end
    adr1 = '0; adr2 = '0;
  endtask

  task automatic test_rr();
    logic [NREQ-1:0] exp_g;
    set_req(0, 5'd1, 32'h100);
    set_req(1, 5'd2, 32'h101);
    set_req(2, 5'd3, 32'h102);
    @(negedge clk);
    req_valid = 3'b111;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      exp_g = 3'b001 << (c % 3);
      #1;
      checks++;
      if (req_ready !== exp_g) begin errors++; $display("FAIL rr_grant[%0d] got=%b exp=%b", c, req_ready, exp_g); end
      @(posedge clk); #1;
      checks++;
      if (rf_en !== 1'b1 || rf_w_adr !== 5'((c % 3) + 1) || rf_w_data !== 32'h100 + 32'(c % 3)) begin
        errors++; $display("FAIL rr_write[%0d] got en=%b adr=%0d data=%h exp adr=%0d", c, rf_en, rf_w_adr, rf_w_data, (c % 3) + 1);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    // rr pointer is 1 and rf_en=1 at this point; pull reset mid-cycle
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    checks++;
    if (rf_en !== 1'b0 || req_ready !== 3'b000 || rf_w_adr !== 5'd0) begin
      errors++; $display("FAIL areset got en=%b ready=%b adr=%0d exp 0/000/0", rf_en, req_ready, rf_w_adr);
    end
    @(negedge clk);
    rst_n = 1'b1; #1;
    checks++;
    if (req_ready !== 3'b001) begin errors++; $display("FAIL areset_regrant got=%b exp=001", req_ready); end
    @(posedge clk); #1;
    checks++;
    if (rf_en !== 1'b1 || rf_w_adr !== 5'd1) begin
      errors++; $display("FAIL areset_write got en=%b adr=%0d exp 1/1", rf_en, rf_w_adr);
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_fixed_prio();
    set_req(0, 5'd1, 32'h100);
    set_req(1, 5'd2, 32'h101);
    set_req(2, 5'd3, 32'h102);
    @(negedge clk);
    req_valid = 3'b111;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (req_ready !== 3'b001) begin errors++; $display("FAIL fixed_grant[%0d] got=%b exp=001", c, req_ready); end
      @(posedge clk); #1;
      checks++;
      if (rf_en !== 1'b1 || rf_w_adr !== 5'd1) begin
        errors++; $display("FAIL fixed_write[%0d] got en=%b adr=%0d exp 1/1", c, rf_en, rf_w_adr);
      end
      @(negedge clk);
    end
    req_valid = 3'b110; #1;
    checks++;
    if (req_ready !== 3'b010) begin errors++; $display("FAIL fixed_next got=%b exp=010", req_ready); end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
`ifdef RF_ARB_FIXED_PRIO_EN
    test_fixed_prio();
    test_hazard();
`else
    test_single();
    test_x0();
    test_stall();
    test_hazard();
    test_rr();
    test_async_reset();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
